// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) in front of one single-port memory, with a per-access timeout.
// Optional performance counters are added when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_wstrb,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_dm_wait,
    output logic [31:0]   perf_conflict,
`endif
    output logic [1:0]    fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;

    localparam int          CW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          busy;
    logic          timeout;
    logic          done;
    logic          grant_dm;
    logic          grant_if;

    assign fsm_state = state;
    assign busy      = (state == BUSY_IF) || (state == BUSY_DM);
    assign timeout   = busy && !mem_ready && (wait_cnt == TO_LIM);
    assign done      = busy && (mem_ready || timeout);

    // An aborted access returns zero data alongside its ready pulse.
    assign if_ready = (state == BUSY_IF) && done;
    assign dm_ready = (state == BUSY_DM) && done;
    assign if_rdata = timeout ? '0 : mem_rdata;
    assign dm_rdata = timeout ? '0 : mem_rdata;

    // Data wins from IDLE; on completion the other side is served next, giving alternation.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        case (state)
            IDLE: begin
                grant_dm = dm_req;
                grant_if = !dm_req && if_req;
            end
            BUSY_IF: grant_dm = done && dm_req;
            BUSY_DM: grant_if = done && if_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (grant_dm) begin
                state     <= BUSY_DM;
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_wstrb <= dm_we ? dm_wstrb : 4'b0;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                state     <= BUSY_IF;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_wstrb <= 4'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (done || !busy) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end

            if (done || !busy) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait  <= '0;
            perf_dm_wait  <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_req && !if_ready) perf_if_wait <= perf_if_wait + 32'd1;
            if (dm_req && !dm_ready) perf_dm_wait <= perf_dm_wait + 32'd1;
            if (state == IDLE && if_req && dm_req) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule
